// File: rtl/vram_scanout_pkg.sv
// rtl/vram_scanout_pkg.sv - shared types and constants for the VRAM scan-out prefetcher
package vram_scanout_pkg;

  typedef enum logic {
    MODE_RGB565 = 1'b0,
    MODE_IDX8   = 1'b1
  } mode_e;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam logic [15:0] DEFAULT_UNDER_COLOR = 16'hF800;

endpackage

// File: rtl/vram_prefetch_fifo.sv
// rtl/vram_prefetch_fifo.sv - synchronous word FIFO with flush and fill-level output
module vram_prefetch_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 32
) (
  input  logic                   clock,
  input  logic                   RESET,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty    = (level == '0);
  assign full     = (level == (PW+1)'(DEPTH));
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  // First-word fall-through: head word is visible before the pop.
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vram_scanout_prefetcher.sv
// rtl/vram_scanout_prefetcher.sv - VRAM prefetch into a FIFO and per-strobe RGB565 / 8bpp pixel unpack
module vram_scanout_prefetcher
  import vram_scanout_pkg::*;
#(
  parameter int          DW          = 16,
  parameter int          AW          = 20,
  parameter int          DEPTH       = 32,
  parameter int          READ_LAT    = 1,
  parameter int          ADDR_STEP   = 2,
  parameter logic [15:0] UNDER_COLOR = DEFAULT_UNDER_COLOR
) (
  input  logic                   clock,
  input  logic                   RESET,
  input  logic                   frameStart,
  input  logic                   pixelEn,
  input  logic                   pixelActive,
  input  logic                   mode,
  input  logic [AW-1:0]          baseAddress,
  input  logic [AW-1:0]          maxVramAddress,
  input  logic [AW-1:0]          frameWords,
  input  logic                   bus_free,
  input  logic [DW-1:0]          dataInputBus,
  output logic [AW-1:0]          nextVramAddress,
  output logic                   chipEnable,
  output logic                   readSignal,
  output logic [4:0]             Ri,
  output logic [5:0]             Gi,
  output logic [4:0]             Bi,
  output logic [7:0]             pixIndex,
  output logic                   pixValid,
  output logic                   underflow,
  output logic                   fetchDone,
  output logic [$clog2(DEPTH):0] fifoLevel
);
  localparam int LW = $clog2(DEPTH) + 1;

  mode_e               mode_q;
  logic [AW-1:0]       words_q;
  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       cnt_q;
  logic [AW-1:0]       cnt_inc;
  logic [AW:0]         addr_sum;
  logic [AW-1:0]       addr_next;
  logic [READ_LAT-1:0] vpipe;
  logic [READ_LAT-1:0] vpipe_next;
  logic [LW-1:0]       in_flight;
  logic                credit_ok;
  logic                issue;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [DW-1:0]       pop_data;
  logic                phase_odd;
  logic [7:0]          hold_byte;

  assign fetchDone = cnt_q == words_q;

  // Ring framebuffer: any step landing on or past the wrap point restarts at 0.
  assign addr_sum  = {1'b0, addr_q} + (AW+1)'(ADDR_STEP);
  assign addr_next = (addr_sum >= {1'b0, maxVramAddress}) ? '0 : addr_sum[AW-1:0];
  assign cnt_inc   = cnt_q + AW'(1);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LAT; i++) in_flight = in_flight + LW'(vpipe[i]);
  end

  // Reads already issued count against free space so a push can never hit a full FIFO.
  assign credit_ok = (32'(fifoLevel) + 32'(in_flight)) < 32'(DEPTH);
  assign issue     = !frameStart && !fetchDone && !bus_free && credit_ok;

  always_comb begin
    vpipe_next    = '0;
    vpipe_next[0] = issue;
    for (int i = 1; i < READ_LAT; i++) vpipe_next[i] = vpipe[i-1];
  end

  assign push = vpipe[READ_LAT-1] && !frameStart;
  assign pop  = !frameStart && pixelEn && pixelActive && !fifo_empty &&
                ((mode_q == MODE_RGB565) || !phase_odd);

  vram_prefetch_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .RESET     (RESET),
    .flush     (frameStart),
    .push      (push),
    .push_data (dataInputBus),
    .pop       (pop),
    .pop_data  (pop_data),
    .level     (fifoLevel),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or posedge RESET) begin
    if (RESET) begin
      chipEnable      <= 1'b1;
      readSignal      <= 1'b1;
      nextVramAddress <= '0;
      addr_q          <= '0;
      cnt_q           <= '0;
      words_q         <= '0;
      mode_q          <= MODE_RGB565;
      vpipe           <= '0;
    end else if (frameStart) begin
      chipEnable      <= 1'b1;
      readSignal      <= 1'b1;
      addr_q          <= baseAddress;
      cnt_q           <= '0;
      words_q         <= frameWords;
      mode_q          <= mode_e'(mode);
      vpipe           <= '0;
    end else begin
      chipEnable <= !issue;
      readSignal <= !issue;
      vpipe      <= vpipe_next;
      if (issue) begin
        nextVramAddress <= addr_q;
        addr_q          <= addr_next;
        cnt_q           <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge RESET) begin
    if (RESET) begin
      Ri        <= '0;
      Gi        <= '0;
      Bi        <= '0;
      pixIndex  <= '0;
      pixValid  <= 1'b0;
      underflow <= 1'b0;
      phase_odd <= 1'b0;
      hold_byte <= '0;
    end else if (frameStart) begin
      underflow <= 1'b0;
      phase_odd <= 1'b0;
    end else if (pixelEn) begin
      if (!pixelActive) begin
        Ri       <= '0;
        Gi       <= '0;
        Bi       <= '0;
        pixIndex <= '0;
        pixValid <= 1'b0;
      end else if (mode_q == MODE_RGB565) begin
        pixValid <= 1'b1;
        pixIndex <= '0;
        if (fifo_empty) begin
          Ri        <= UNDER_COLOR[R_MSB:R_LSB];
          Gi        <= UNDER_COLOR[G_MSB:G_LSB];
          Bi        <= UNDER_COLOR[B_MSB:B_LSB];
          underflow <= 1'b1;
        end else begin
          Ri <= pop_data[R_MSB:R_LSB];
          Gi <= pop_data[G_MSB:G_LSB];
          Bi <= pop_data[B_MSB:B_LSB];
        end
      end else begin
        pixValid <= 1'b1;
        Ri       <= '0;
        Gi       <= '0;
        Bi       <= '0;
        // Odd pixels replay the high byte kept from the previous pop.
        if (phase_odd) begin
          pixIndex  <= hold_byte;
          phase_odd <= 1'b0;
        end else if (fifo_empty) begin
          pixIndex  <= 8'h00;
          underflow <= 1'b1;
        end else begin
          pixIndex  <= pop_data[7:0];
          hold_byte <= pop_data[15:8];
          phase_odd <= 1'b1;
        end
      end
    end
  end

endmodule
